// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : two-master arbiter for the shared 256-bit Data_Memory port
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [LINE_W-1:0] m0_data_o,

  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [LINE_W-1:0] m1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               WD_EN   = (TIMEOUT > 0);
  localparam logic [WD_W-1:0]  WD_LAST = WD_EN ? WD_W'(TIMEOUT - 1) : '0;
  localparam bit               PRIO_M1 = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        grant_q;
  logic              last_q;      // 1: m1 owned the most recent transfer
  logic              mem_en_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;

  logic              w_busy;
  logic              w_req_any;
  logic              w_pick_m1;
  logic              w_tmo;
  logic              w_done;
  logic [LINE_W-1:0] w_rd_data;

  assign w_busy    = (state_q == S_BUSY);
  assign w_req_any = m0_enable_i | m1_enable_i;

  // A tie goes to m1 in fixed mode, otherwise to whoever did not own last.
  assign w_pick_m1 = (m0_enable_i & m1_enable_i) ? (PRIO_M1 ? 1'b1 : ~last_q)
                                                 : m1_enable_i;

  // The final permitted BUSY cycle doubles as the abort cycle; a real ack
  // arriving in that same cycle still completes the transfer normally.
  assign w_tmo  = WD_EN & w_busy & (wd_q == WD_LAST) & ~mem_ack_i;
  assign w_done = w_busy & (mem_ack_i | w_tmo);

  assign w_rd_data = (w_busy & mem_ack_i & ~write_q) ? mem_data_i : '0;

  assign m0_ack_o  = w_done & grant_q[0];
  assign m1_ack_o  = w_done & grant_q[1];
  assign m0_data_o = grant_q[0] ? w_rd_data : '0;
  assign m1_data_o = grant_q[1] ? w_rd_data : '0;

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign grant_o      = grant_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      mem_en_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_req_any) begin
            state_q  <= S_BUSY;
            mem_en_q <= 1'b1;
            grant_q  <= w_pick_m1 ? 2'b10 : 2'b01;
            write_q  <= w_pick_m1 ? m1_write_i : m0_write_i;
            addr_q   <= w_pick_m1 ? m1_addr_i  : m0_addr_i;
            data_q   <= w_pick_m1 ? m1_data_i  : m0_data_i;
            wd_q     <= '0;
          end
        end

        S_BUSY: begin
          if (w_done) begin
            state_q  <= S_RELEASE;
            mem_en_q <= 1'b0;
            grant_q  <= 2'b00;
            // An aborted transfer still counts as a turn for fairness.
            last_q   <= grant_q[1];
            wd_q     <= '0;
            if (w_tmo) begin
              err_q <= 1'b1;
            end
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end

        S_RELEASE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          mem_en_q <= 1'b0;
          grant_q  <= 2'b00;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: instance 0 is round-robin with the default
// watchdog, instance 1 is fixed-priority with an 8-cycle watchdog.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int TO_A = 64;
  localparam int TO_B = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en   [2][2];
  logic          wr   [2][2];
  logic [AW-1:0] addr [2][2];
  logic [LW-1:0] wdat [2][2];
  logic          ack  [2][2];
  logic [LW-1:0] rdat [2][2];
  logic          menb [2];
  logic          mwr  [2];
  logic          mack [2];
  logic [AW-1:0] maddr[2];
  logic [LW-1:0] mdo  [2];
  logic [LW-1:0] mdi  [2];
  logic [1:0]    gnt  [2];
  logic          err  [2];

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(0), .TIMEOUT(TO_A)) u_rr (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(en[0][0]), .m0_write_i(wr[0][0]), .m0_addr_i(addr[0][0]), .m0_data_i(wdat[0][0]),
    .m0_ack_o(ack[0][0]), .m0_data_o(rdat[0][0]),
    .m1_enable_i(en[0][1]), .m1_write_i(wr[0][1]), .m1_addr_i(addr[0][1]), .m1_data_i(wdat[0][1]),
    .m1_ack_o(ack[0][1]), .m1_data_o(rdat[0][1]),
    .mem_enable_o(menb[0]), .mem_write_o(mwr[0]), .mem_addr_o(maddr[0]), .mem_data_o(mdo[0]),
    .mem_ack_i(mack[0]), .mem_data_i(mdi[0]), .grant_o(gnt[0]), .err_o(err[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1), .TIMEOUT(TO_B)) u_fp (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(en[1][0]), .m0_write_i(wr[1][0]), .m0_addr_i(addr[1][0]), .m0_data_i(wdat[1][0]),
    .m0_ack_o(ack[1][0]), .m0_data_o(rdat[1][0]),
    .m1_enable_i(en[1][1]), .m1_write_i(wr[1][1]), .m1_addr_i(addr[1][1]), .m1_data_i(wdat[1][1]),
    .m1_ack_o(ack[1][1]), .m1_data_o(rdat[1][1]),
    .mem_enable_o(menb[1]), .mem_write_o(mwr[1]), .mem_addr_o(maddr[1]), .mem_data_o(mdo[1]),
    .mem_ack_i(mack[1]), .mem_data_i(mdi[1]), .grant_o(gnt[1]), .err_o(err[1])
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        en[d][m] = 1'b0; wr[d][m] = 1'b0; addr[d][m] = '0; wdat[d][m] = '0;
      end
      mack[d] = 1'b0;
      mdi[d]  = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 2; d++) begin
      chk1("rst_men", menb[d], 1'b0);
      chkn("rst_gnt", LW'(gnt[d]), '0);
      chk1("rst_ack0", ack[d][0], 1'b0);
      chk1("rst_ack1", ack[d][1], 1'b0);
      chk1("rst_err", err[d], 1'b0);
      chk1("rst_wr", mwr[d], 1'b0);
      chkn("rst_addr", LW'(maddr[d]), '0);
      chkn("rst_data", mdo[d], '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Round-robin tie sequence on the round-robin instance.
  typedef struct {
    logic       en0;
    logic       en1;
    logic       mk;
    logic       e_men;
    logic [1:0] e_gnt;
    logic       e_a0;
    logic       e_a1;
  } vec_t;
  vec_t tbl[15];

  // Higher-level reference: one transfer owner at a time, one cooldown cycle
  // after each completion, arbitration only while nobody owns the port.
  task automatic rand_run(input int d, input int n);
    int owner, bc, last, lat, to;
    bit fp, cool, errm, done, tmo, mk;
    bit req[2];
    bit hold[2];
    logic [AW-1:0] la;
    logic          lw;
    logic [LW-1:0] ld;
    logic [1:0]    eg;
    fp = (d == 1); to = (d == 0) ? TO_A : TO_B;
    owner = -1; bc = 0; last = 1; lat = 0; cool = 0; errm = 0;
    req = '{0, 0}; hold = '{0, 0}; la = '0; lw = 1'b0; ld = '0;
    for (int c = 0; c < n; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && !hold[m] && $urandom_range(0, 2) == 0) req[m] = 1;
        hold[m] = 0;
        en[d][m] = req[m]; wr[d][m] = 1'($urandom_range(0, 1));
        addr[d][m] = $urandom; wdat[d][m] = rnd_line();
      end
      mk = (owner >= 0) ? (bc + 1 == lat) : ($urandom_range(0, 5) == 0);
      mack[d] = mk;
      mdi[d]  = rnd_line();
      tmo  = (owner >= 0) && (to > 0) && (bc + 1 == to) && !mk;
      done = (owner >= 0) && (mk || tmo);
      eg   = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      #2;
      chk1("rnd_men", menb[d], owner >= 0);
      chkn("rnd_gnt", LW'(gnt[d]), LW'(eg));
      chk1("rnd_ack0", ack[d][0], done && owner == 0);
      chk1("rnd_ack1", ack[d][1], done && owner == 1);
      chk1("rnd_err", err[d], errm);
      if (owner >= 0) begin
        chkn("rnd_maddr", LW'(maddr[d]), LW'(la));
        chk1("rnd_mwr", mwr[d], lw);
        chkn("rnd_mdata", mdo[d], ld);
        if (done && !(mk && lw)) chkn("rnd_rdata", rdat[d][owner], (mk && !lw) ? mdi[d] : '0);
      end
      if (owner >= 0) begin
        if (done) begin
          last = owner; req[owner] = 0; hold[owner] = 1;
          if (tmo) errm = 1;
          owner = -1; cool = 1;
        end else begin
          bc++;
        end
      end else if (cool) begin
        cool = 0;
      end else if (req[0] || req[1]) begin
        if (req[0] && req[1]) owner = fp ? 1 : ((last == 1) ? 0 : 1);
        else owner = req[1] ? 1 : 0;
        la = addr[d][owner]; lw = wr[d][owner]; ld = wdat[d][owner];
        bc = 0; lat = $urandom_range(1, (d == 1) ? 11 : 10);
      end
      next_cycle();
    end
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  logic [LW-1:0] pat;
  logic [LW-1:0] wpat;
  logic [LW-1:0] got;
  int nb, na0, na1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 2'b00, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 2'b01, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 2'b01, 1, 0};
    tbl[3]  = '{0, 1, 1, 0, 2'b00, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 2'b00, 0, 0};
    tbl[5]  = '{1, 1, 1, 1, 2'b10, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 2'b00, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 2'b00, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 2'b01, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 2'b01, 1, 0};
    tbl[10] = '{0, 1, 0, 0, 2'b00, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 2'b00, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 2'b10, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 2'b00, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 2'b00, 0, 0};
    for (int i = 0; i < 16; i++) begin
      pat[(15-i)*16 +: 16]  = {4{4'(i)}};
      wpat[(15-i)*16 +: 16] = {4'(i), 8'h00, 4'(i)};
    end

    do_reset();

    // Round-robin tie, both masters held: m0, m1, m0, m1.
    addr[0][0] = 32'h100; addr[0][1] = 32'h200;
    for (int i = 0; i < 15; i++) begin
      en[0][0] = tbl[i].en0; en[0][1] = tbl[i].en1; mack[0] = tbl[i].mk;
      #2;
      chk1($sformatf("tbl%0d_men", i), menb[0], tbl[i].e_men);
      chkn($sformatf("tbl%0d_gnt", i), LW'(gnt[0]), LW'(tbl[i].e_gnt));
      chk1($sformatf("tbl%0d_ack0", i), ack[0][0], tbl[i].e_a0);
      chk1($sformatf("tbl%0d_ack1", i), ack[0][1], tbl[i].e_a1);
      if (tbl[i].e_men)
        chkn($sformatf("tbl%0d_addr", i), LW'(maddr[0]), tbl[i].e_gnt[1] ? LW'(32'h200) : LW'(32'h100));
      next_cycle();
    end
    idle_inputs();

    // m0 read of address 0, memory acks in the 10th enable cycle.
    en[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = '0; mdi[0] = pat;
    nb = 0; na0 = 0; na1 = 0; got = '0;
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      mack[0] = (nb == 9);
      #2;
      if (menb[0]) nb++;
      if (ack[0][0]) begin na0++; got = rdat[0][0]; end
      if (ack[0][1]) na1++;
      next_cycle();
      mack[0] = 1'b0;
      if (na0 > 0) en[0][0] = 1'b0;
    end
    chkn("rd_enable_cycles", LW'(nb), LW'(10));
    chkn("rd_ack0_pulses", LW'(na0), LW'(1));
    chkn("rd_ack1_pulses", LW'(na1), LW'(0));
    chkn("rd_data", got, pat);
    idle_inputs();

    // m1 write to 0x400; inputs change mid-transfer, memory side must not.
    en[0][1] = 1'b1; wr[0][1] = 1'b1; addr[0][1] = 32'h400; wdat[0][1] = wpat;
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin addr[0][1] = 32'h20; wdat[0][1] = ~wpat; wr[0][1] = 1'b0; end
      mack[0] = (k == 6);
      #2;
      chk1("wr_men", menb[0], 1'b1);
      chkn("wr_gnt", LW'(gnt[0]), LW'(2'b10));
      chkn("wr_addr", LW'(maddr[0]), LW'(32'h400));
      chkn("wr_data", mdo[0], wpat);
      chk1("wr_write", mwr[0], 1'b1);
      chk1("wr_ack1", ack[0][1], k == 6);
      chk1("wr_ack0", ack[0][0], 1'b0);
      next_cycle();
    end
    en[0][1] = 1'b0; mack[0] = 1'b0;
    #2;
    chk1("wr_release_men", menb[0], 1'b0);
    next_cycle();
    idle_inputs();

    // Fixed priority: m1 first, m0 only after RELEASE and IDLE.
    en[1][0] = 1'b1; en[1][1] = 1'b1; addr[1][0] = 32'h10; addr[1][1] = 32'h20;
    #2;
    chkn("fp_idle_gnt", LW'(gnt[1]), '0);
    next_cycle();
    mack[1] = 1'b1;
    #2;
    chkn("fp_first_gnt", LW'(gnt[1]), LW'(2'b10));
    chk1("fp_first_ack1", ack[1][1], 1'b1);
    chk1("fp_first_ack0", ack[1][0], 1'b0);
    next_cycle();
    en[1][1] = 1'b0; mack[1] = 1'b0;
    #2;
    chk1("fp_release_men", menb[1], 1'b0);
    chkn("fp_release_gnt", LW'(gnt[1]), '0);
    next_cycle();
    #2;
    chk1("fp_idle2_men", menb[1], 1'b0);
    next_cycle();
    mack[1] = 1'b1;
    #2;
    chkn("fp_second_gnt", LW'(gnt[1]), LW'(2'b01));
    chkn("fp_second_addr", LW'(maddr[1]), LW'(32'h10));
    chk1("fp_second_ack0", ack[1][0], 1'b1);
    next_cycle();
    en[1][0] = 1'b0; mack[1] = 1'b0;
    repeat (2) next_cycle();

    // Watchdog: no ack for 8 BUSY cycles aborts with a zero-data ack.
    en[1][0] = 1'b1; wr[1][0] = 1'b0; addr[1][0] = 32'h40; mdi[1] = pat;
    next_cycle();
    for (int k = 1; k <= TO_B; k++) begin
      #2;
      chk1("to_men", menb[1], 1'b1);
      chk1("to_ack0", ack[1][0], k == TO_B);
      chk1("to_err_before", err[1], 1'b0);
      if (k == TO_B) chkn("to_data", rdat[1][0], '0);
      next_cycle();
    end
    en[1][0] = 1'b0; en[1][1] = 1'b1; addr[1][1] = 32'h80;
    #2;
    chk1("to_err_set", err[1], 1'b1);
    chk1("to_release_men", menb[1], 1'b0);
    chk1("to_release_ack0", ack[1][0], 1'b0);
    next_cycle();
    #2;
    chkn("to_idle_gnt", LW'(gnt[1]), '0);
    next_cycle();
    mack[1] = 1'b1; mdi[1] = wpat;
    #2;
    chkn("to_next_gnt", LW'(gnt[1]), LW'(2'b10));
    chkn("to_next_addr", LW'(maddr[1]), LW'(32'h80));
    chk1("to_next_ack1", ack[1][1], 1'b1);
    chkn("to_next_data", rdat[1][1], wpat);
    chk1("to_err_sticky", err[1], 1'b1);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();

    // Randomized traffic on both instances against the reference model.
    do_reset();
    rand_run(0, 1500);
    do_reset();
    rand_run(1, 1500);

    // Asynchronous reset in BUSY cycle 5, then the tie goes to m0 again.
    do_reset();
    en[0][0] = 1'b1; en[0][1] = 1'b1; addr[0][0] = 32'h500; addr[0][1] = 32'h600;
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk1("rm_busy_men", menb[0], 1'b1);
      next_cycle();
    end
    #1;
    rst_n = 1'b0; mack[0] = 1'b1;
    #1;
    chk1("rm_men", menb[0], 1'b0);
    chkn("rm_gnt", LW'(gnt[0]), '0);
    chk1("rm_ack0", ack[0][0], 1'b0);
    chk1("rm_ack1", ack[0][1], 1'b0);
    next_cycle();
    rst_n = 1'b1; mack[0] = 1'b0;
    #2;
    chk1("rm_idle_men", menb[0], 1'b0);
    next_cycle();
    mack[0] = 1'b1;
    #2;
    chkn("rm_regrant_gnt", LW'(gnt[0]), LW'(2'b01));
    chkn("rm_regrant_addr", LW'(maddr[0]), LW'(32'h500));
    chk1("rm_regrant_ack0", ack[0][0], 1'b1);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
